wave_field: RTL and testbench

- Parametrised, clocked successor to the single-crest wave renderer.
- Draws a scrolling row of NUM_WAVES identical circular crests, evenly spaced, plus a fixed surface band at the top of the screen.
- Crest row scrolls left by SPEED px per frame and wraps seamlessly.
- Pixel test is a 2-stage pipeline driven by the VGA timing counters; output feeds the colour mux in the top-level display path.

---
 rtl/wave_field_if.sv | 22 ++
 rtl/wave_field.sv | 145 ++++++++++++++
 tb/tb_wave_field.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wave_field_if.sv
// Pixel/frame bus of the scrolling crest renderer: timing counters in,
// pixel flag and scroll status out.
interface wave_field_if;
    logic               frame_tick;
    logic               pause;
    logic               blank;
    logic signed [10:0] hcount;
    logic signed [10:0] vcount;
    logic               wave;
    logic signed [11:0] phase_x;
    logic               wrap_pulse;

    modport master (
        output frame_tick, pause, blank, hcount, vcount,
        input  wave, phase_x, wrap_pulse
    );

    modport slave (
        input  frame_tick, pause, blank, hcount, vcount,
        output wave, phase_x, wrap_pulse
    );
endinterface

// File: rtl/wave_field.sv
// Scrolling row of NUM_WAVES circular crests plus a surface band, 2-cycle pixel pipeline.
// Optional vertical bob of the crest row is enabled by defining WAVE_BOB_EN.
module wave_field #(
    parameter int NUM_WAVES    = 7,
    parameter int SPACING_LOG2 = 7,
    parameter int RADIUS       = 32,
    parameter int BASE_Y       = 36,
    parameter int SURF_H       = 36,
    parameter int SPEED        = 2,
    parameter int AMP          = 8
) (
    input  logic       clk,
    input  logic       rst,
    wave_field_if.slave bus
);
    localparam int                 DXW    = SPACING_LOG2 + 1;
    localparam logic signed [11:0] PITCH  = 12'(1 << SPACING_LOG2);
    localparam logic signed [11:0] STEP   = 12'(SPEED);
    localparam logic signed [11:0] BASE   = 12'(BASE_Y);
    localparam logic signed [11:0] SURF_V = 12'(SURF_H);
    localparam logic signed [11:0] SURF_W = 12'sd640;
    localparam logic signed [11:0] NW     = 12'(NUM_WAVES);
    localparam logic        [23:0] R2     = 24'(RADIUS * RADIUS);

    logic signed [11:0] phase_x;
    logic               wrap_pulse;
    logic signed [11:0] bob_ext;
    logic signed [11:0] t;

    wire advance = bus.frame_tick && !bus.pause;

`ifdef WAVE_BOB_EN
    localparam int BW = $clog2(AMP + 1);
    logic [BW-1:0] bob;
    logic          bob_up;

    // The tick that hits an end stop already steps the other way: 7, 8, 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            bob    <= '0;
            bob_up <= 1'b1;
        end else if (advance) begin
            if (bob_up) begin
                if (bob == BW'(AMP)) begin
                    bob_up <= 1'b0;
                    bob    <= bob - 1'b1;
                end else begin
                    bob    <= bob + 1'b1;
                end
            end else begin
                if (bob == '0) begin
                    bob_up <= 1'b1;
                    bob    <= bob + 1'b1;
                end else begin
                    bob    <= bob - 1'b1;
                end
            end
        end
    end

    assign bob_ext = 12'(bob);
`else
    assign bob_ext = '0;
`endif

    assign t = phase_x - STEP;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_x    <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (advance) begin
                if (t <= -PITCH) begin
                    phase_x    <= t + PITCH;
                    wrap_pulse <= 1'b1;
                end else begin
                    phase_x    <= t;
                end
            end
        end
    end

    // Stage 1: fold the column onto the nearest crest.
    logic signed [11:0]      hx, vy, rel, k_base, k, dy;
    logic        [DXW-2:0]   m;
    logic signed [DXW-1:0]   dx;
    logic                    in_range, surf;

    assign hx     = bus.hcount;
    assign vy     = bus.vcount;
    assign rel    = hx - phase_x;
    assign m      = rel[SPACING_LOG2-1:0];
    assign k_base = rel >>> SPACING_LOG2;

    // Sign-extending m by its own MSB yields m - pitch exactly when m is in the upper half.
    assign dx       = $signed({m[SPACING_LOG2-1], m});
    assign k        = k_base + {11'd0, m[SPACING_LOG2-1]};
    assign dy       = vy - (BASE + bob_ext);
    assign in_range = (k >= 12'sd0) && (k < NW);
    assign surf     = (hx >= 12'sd0) && (hx <= SURF_W) && (vy >= 12'sd0) && (vy < SURF_V);

    logic signed [DXW-1:0] dx_q;
    logic signed [11:0]    dy_q;
    logic                  in_range_q, surf_q, blank_q;

    // NOTE: the pipeline is reset too, so wave stays low for two cycles after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q       <= '0;
            dy_q       <= '0;
            in_range_q <= 1'b0;
            surf_q     <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            dx_q       <= dx;
            dy_q       <= dy;
            in_range_q <= in_range;
            surf_q     <= surf;
            blank_q    <= bus.blank;
        end
    end

    // Stage 2: magnitudes fit unsigned even for the most negative codes.
    logic [DXW-1:0] adx;
    logic [11:0]    ady;
    logic [23:0]    dist2;
    logic           wave_q;

    assign adx   = dx_q[DXW-1] ? DXW'(-dx_q) : DXW'(dx_q);
    assign ady   = dy_q[11]    ? 12'(-dy_q)  : 12'(dy_q);
    assign dist2 = 24'(adx) * 24'(adx) + 24'(ady) * 24'(ady);

    always_ff @(posedge clk) begin
        if (rst) wave_q <= 1'b0;
        else     wave_q <= !blank_q && (surf_q || (in_range_q && (dist2 <= R2)));
    end

    assign bus.wave       = wave_q;
    assign bus.phase_x    = phase_x;
    assign bus.wrap_pulse = wrap_pulse;
endmodule

// File: tb/tb_wave_field.sv
// Self-checking bench for wave_field: fixed pixel vectors, scroll/pause/reset
// sequences and randomized traffic against a geometric reference model.
module tb_wave_field;
    localparam int NUM_WAVES = 7;
    localparam int PITCH     = 128;
    localparam int RADIUS    = 32;
    localparam int BASE_Y    = 36;
    localparam int SURF_H    = 36;
    localparam int SPEED     = 2;
    localparam int AMP       = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wave_field_if bus();

    wave_field dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int h;
        int v;
        bit blk;
        int exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   ticks     = 0;
    bit   exp_wrap  = 1'b0;
    int   wrap_seen = 0;
    int   pipe[$];

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Total scroll distance folded into one pitch.
    function automatic int model_phase();
        return -((ticks * SPEED) % PITCH);
    endfunction

    function automatic int model_bob();
`ifdef WAVE_BOB_EN
        int p;
        p = ticks % (2 * AMP);
        return (p <= AMP) ? p : 2 * AMP - p;
`else
        return 0;
`endif
    endfunction

    function automatic int model_pixel(input int h, input int v, input bit blk);
        int dx, dy;
        if (blk) return 0;
        if (h >= 0 && h <= 640 && v >= 0 && v < SURF_H) return 1;
        for (int k = 0; k < NUM_WAVES; k++) begin
            dx = h - (model_phase() + k * PITCH);
            dy = v - (BASE_Y + model_bob());
            if (dx * dx + dy * dy <= RADIUS * RADIUS) return 1;
        end
        return 0;
    endfunction

    // One cycle: check what the DUT shows now, then drive the next inputs.
    task automatic step(input bit tick, input bit pse, input bit blk, input int h, input int v,
                        input bit do_rst = 1'b0, input int exp_px = -1);
        int e;
        @(negedge clk);
        e = pipe.pop_front();
        check("wave", bus.wave, e);
        check("phase_x", bus.phase_x, model_phase());
        check("wrap_pulse", bus.wrap_pulse, exp_wrap);
        if (bus.wrap_pulse === 1'b1) wrap_seen++;

        rst            = do_rst;
        bus.frame_tick = tick;
        bus.pause      = pse;
        bus.blank      = blk;
        bus.hcount     = 11'(h);
        bus.vcount     = 11'(v);

        exp_wrap = 1'b0;
        if (do_rst) begin
            pipe.delete();
            pipe.push_back(0);
            pipe.push_back(0);
            ticks = 0;
        end else begin
            pipe.push_back(exp_px >= 0 ? exp_px : model_pixel(h, v, blk));
            if (tick && !pse) begin
                ticks++;
                exp_wrap = ((ticks * SPEED) / PITCH) != (((ticks - 1) * SPEED) / PITCH);
            end
        end
    endtask

    function automatic int rand_h();
        return int'($urandom_range(860)) - 60;
    endfunction

    function automatic int rand_v();
        return int'($urandom_range(140)) - 20;
    endfunction

    task automatic add(input int h, input int v, input bit blk, input int exp);
        vec_t r;
        r.h = h; r.v = v; r.blk = blk; r.exp = exp;
        vecs.push_back(r);
    endtask

    initial begin
        // Phase 0, bob 0 after reset; expectations worked out by hand.
        add(32, 36, 0, 1);    // rim of crest 0, distance exactly RADIUS
        add(33, 36, 0, 0);
        add(100, 10, 0, 1);   // surface band
        add(100, 36, 0, 1);   // crest 1, dx=-28
        add(64, 36, 0, 0);    // midway between crests
        add(32, 36, 1, 0);    // blanked
        add(0, 36, 0, 1);
        add(-32, 36, 0, 1);
        add(-33, 36, 0, 0);
        add(640, 0, 0, 1);    // last surface column
        add(641, 0, 0, 0);
        add(768, 36, 0, 1);   // crest 6
        add(896, 36, 0, 0);   // would-be crest 7
        add(0, -1, 0, 0);
        add(20, 60, 0, 1);
        add(24, 60, 0, 0);

        // NOTE: stimulus is driven with blocking assignments at the falling edge.
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.pause      = 1'b0;
        bus.blank      = 1'b0;
        bus.hcount     = '0;
        bus.vcount     = '0;
        pipe.push_back(0);
        pipe.push_back(0);
        @(negedge clk);

        foreach (vecs[i]) step(0, 0, vecs[i].blk, vecs[i].h, vecs[i].v, 1'b0, vecs[i].exp);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // 64 ticks wrap back to phase 0 with exactly one pulse.
        step(0, 0, 0, 0, 0, 1'b1);
        wrap_seen = 0;
        for (int i = 0; i < 64; i++) step(1, 0, 0, rand_h(), rand_v());
        step(0, 0, 0, 32, 36);
        check("phase_after_64_ticks", bus.phase_x, 0);
        check("wraps_in_64_ticks", wrap_seen, 1);

        // Paused ticks change nothing.
        for (int i = 0; i < 5; i++) step(1, 0, 0, rand_h(), rand_v());
        wrap_seen = 0;
        for (int i = 0; i < 10; i++) step(1, 1, 0, rand_h(), rand_v());
        step(0, 0, 0, 100, 10);
        check("phase_after_pause", bus.phase_x, -10);
        check("wraps_while_paused", wrap_seen, 0);

        // Reset while wave is high: two zero cycles, phase back to 0.
        step(0, 0, 0, 100, 10);
        step(0, 0, 0, 100, 10);
        check("wave_before_rst", bus.wave, 1);
        step(0, 0, 0, 100, 10, 1'b1);
        step(0, 0, 0, 100, 10);
        check("wave_rst_cycle1", bus.wave, 0);
        step(0, 0, 0, 100, 10);
        check("wave_rst_cycle2", bus.wave, 0);
        step(0, 0, 0, 100, 10);
        check("wave_after_rst", bus.wave, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                 rand_h(), rand_v(), ($urandom_range(499) == 0));
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
